// File: rtl/conv2_pool_pkg.sv
// Shared widths, FSM state type and ReLU/saturation helper
// for the conv2 max-pool output stage.
package conv2_pool_pkg;

  localparam int DATA_W = 14;
  localparam int OUT_W = 12;
  localparam int IN_COLS = 8;
  localparam int IN_ROWS = 8;
  localparam int POOL_COLS = IN_COLS / 2;

  localparam logic signed [DATA_W-1:0] SAT_MAX =
    DATA_W'(2 ** (OUT_W - 1) - 1);
  localparam logic [OUT_W-1:0] OUT_MAX =
    OUT_W'(2 ** (OUT_W - 1) - 1);

  typedef enum logic {
    ROW_TOP = 1'b0,
    ROW_BOT = 1'b1
  } state_t;

  function automatic logic [OUT_W-1:0] relu_sat(
    input logic signed [DATA_W-1:0] m
  );
    logic [OUT_W-1:0] r;
    r = '0;
    if (m[DATA_W-1]) r = '0;
    else if (m > SAT_MAX) r = OUT_MAX;
    else r = m[OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational signed maximum of two conv sums.
// On a tie either operand is equivalent.
module pool_max2
  import conv2_pool_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  assign y = (a > b) ? a : b;

endmodule

// File: rtl/conv2_maxpool_relu.sv
// 2x2/stride-2 max pool + ReLU + saturation over a raster
// stream of conv2 sums; one instance per output channel.
module conv2_maxpool_relu
  import conv2_pool_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic [OUT_W-1:0]         data_out,
  output logic                     valid_out,
  output logic                     frame_done
);

  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  state_t        state;

  logic signed [DATA_W-1:0] pair_reg;
  logic signed [DATA_W-1:0] rowbuf [POOL_COLS];
  logic signed [DATA_W-1:0] max_pair;
  logic signed [DATA_W-1:0] max_win;
  logic [CW-2:0]            slot;

  assign slot = col[CW-1:1];

  pool_max2 u_max_pair (
    .a (pair_reg),
    .b (data_in),
    .y (max_pair)
  );

  pool_max2 u_max_win (
    .a (max_pair),
    .b (rowbuf[slot]),
    .y (max_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      state      <= ROW_TOP;
      pair_reg   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < POOL_COLS; i++) rowbuf[i] <= '0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        case (state)
          ROW_TOP: begin
            if (!col[0]) pair_reg <= data_in;
            else rowbuf[slot] <= max_pair;
          end
          ROW_BOT: begin
            if (!col[0]) begin
              pair_reg <= data_in;
            end else begin
              data_out   <= relu_sat(max_win);
              valid_out  <= 1'b1;
              frame_done <= (row == ROW_LAST) && (col == COL_LAST);
            end
          end
          default: ;
        endcase
        // Row wrap also flips the top/bottom phase; no idle cycle between frames.
        if (col == COL_LAST) begin
          col   <= '0;
          row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
          state <= (state == ROW_TOP) ? ROW_BOT : ROW_TOP;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// Self-checking bench: window tables, ramps, gaps, reset
// mid-frame and back-to-back frames against a scoreboard.
module tb_conv2_maxpool_relu;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_in = 1'b0;
  logic signed [13:0] data_in = '0;
  logic [11:0]       data_out;
  logic              valid_out;
  logic              frame_done;

  conv2_maxpool_relu dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    bit fd;
    int due;
  } exp_t;

  typedef struct {
    int d0;
    int d1;
    int d2;
    int d3;
    int exp;
  } vec_t;

  exp_t q[$];
  int   img[8][8];
  int   pr = 0;
  int   pc = 0;
  int   force_exp = -1;
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;

  function automatic int ref_relu(input int m);
    if (m < 0) return 0;
    if (m > 2047) return 2047;
    return m;
  endfunction

  task automatic model_push(input int d);
    int m;
    exp_t e;
    img[pr][pc] = d;
    if ((pr % 2 == 1) && (pc % 2 == 1)) begin
      m = img[pr-1][pc-1];
      if (img[pr-1][pc] > m) m = img[pr-1][pc];
      if (img[pr][pc-1] > m) m = img[pr][pc-1];
      if (img[pr][pc] > m) m = img[pr][pc];
      e.val = (force_exp >= 0) ? force_exp : ref_relu(m);
      e.fd  = (pr == 7) && (pc == 7);
      e.due = cyc + 1;
      q.push_back(e);
    end
    if (pc == 7) begin
      pc = 0;
      pr = (pr == 7) ? 0 : pr + 1;
    end else begin
      pc = pc + 1;
    end
  endtask

  task automatic send(input int d, input int gap);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 14'(d);
    model_push(d);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = 14'($urandom_range(0, 16383));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic ramp(input int off, input int mode);
    int gap;
    for (int i = 0; i < 64; i++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 3);
      send(i + off, gap);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_on) continue;
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        errors++;
        checks++;
        $display("FAIL missed_output: no valid_out at cycle %0d, want data %0d",
                 e.due, e.val);
      end
      if (valid_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: valid_out=1 data=%0d at cycle %0d, want none",
                   data_out, cyc);
        end else begin
          e = q.pop_front();
          if (data_out !== 12'(e.val) || frame_done !== e.fd
              || cyc != e.due) begin
            errors++;
            $display("FAIL output: got data=%0d fd=%0b cyc=%0d, want data=%0d fd=%0b cyc=%0d",
                     data_out, frame_done, cyc, e.val, e.fd, e.due);
          end
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL lone_frame_done: frame_done=1 without valid_out at cycle %0d",
                 cyc);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (valid_out !== 1'b0 || frame_done !== 1'b0 || data_out !== 12'd0) begin
      errors++;
      $display("FAIL %s: got vo=%0b fd=%0b data=%0d, want 0 0 0",
               name, valid_out, frame_done, data_out);
    end
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{3000, -5, 7, 12, 2047};
    tbl[1] = '{8191, 8191, 8191, 8191, 2047};
    tbl[2] = '{2047, 0, 0, 0, 2047};
    tbl[3] = '{-100, -100, -100, -100, 0};
    tbl[4] = '{5, -3, 100, 2, 100};
    tbl[5] = '{-8192, -1, -2, -3, 0};
    tbl[6] = '{2046, 2047, 2048, -1, 2047};
    tbl[7] = '{1, 2, 3, 4, 4};
    tbl[8] = '{100, 200, 150, 50, 200};

    fork
      monitor();
    join_none

    rst = 1'b1;
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset_state");
    mon_on = 1'b1;

    // continuous ramp
    ramp(0, 0);

    // tiled windows: every 2x2 window of the frame is the same vector
    for (int t = 0; t < 9; t++) begin
      force_exp = tbl[t].exp;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          case ((r % 2) * 2 + (c % 2))
            0: send(tbl[t].d0, 0);
            1: send(tbl[t].d1, 0);
            2: send(tbl[t].d2, 0);
            default: send(tbl[t].d3, 0);
          endcase
    end
    force_exp = -1;
    idle(3);

    // alternating and random gaps
    ramp(0, 1);
    ramp(0, 2);
    idle(5);

    // reset after 20 samples of a frame
    for (int i = 0; i < 20; i++) send(500 + i, 0);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    q.delete();
    pr = 0;
    pc = 0;
    @(negedge clk);
    rst = 1'b0;
    check_idle("after_mid_reset");
    idle(4);
    check_idle("idle_after_reset");
    ramp(0, 0);

    // back-to-back frames
    ramp(0, 0);
    ramp(100, 0);
    idle(5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs outstanding, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
